uncache_axi_bridge: RTL and testbench
=====================================

Name: uncache_axi_bridge

Overview:
- Responder end of the uncached-access request interface: accepts one single-beat request (en/wsel/addr/wdata) from the uncached tag unit.
- Performs it as one AXI4 single-beat read or write, returns read data and a one-cycle refresh pulse on completion.
- Sits between the uncached tag unit and the SoC AXI interconnect; one transaction outstanding at a time.

Parameters:
- AXI_ID, 4'b0001, value driven on arid/awid.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with UNCACHE_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- req_en  in  1  request valid; held by the requester until refresh.
- req_wsel  in  4  byte write strobe; 4'b0000 means read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_rdata  out  32  read data, valid from the refresh cycle onward.
- refresh  out  1  one-cycle completion pulse.
- arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/8/3/2/1  AXI read address channel.
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI read data channel.
- rready  out  1
- awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/8/3/2/1  AXI write address channel.
- awready  in  1
- wdata/wstrb/wlast/wvalid  out  32/4/1/1  AXI write data channel.
- wready  in  1
- bid/bresp/bvalid  in  4/2/1  AXI write response channel.
- bready  out  1

Behaviour:
- Reset (resetn low, asynchronous): state IDLE.
  - Deasserted to 0: arvalid, awvalid, wvalid, rready, bready, refresh.
  - Cleared to 0: req_rdata and all address, data and strobe outputs.
  - A reset mid-transaction abandons it; no refresh is issued.
- Fixed outputs: arlen = awlen = 0; arburst = awburst = 2'b01; wlast = 1; arid = awid = AXI_ID.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE:
  - On req_en=1, latch addr/wsel/wdata.
  - wsel == 0: go to RD_ADDR with arvalid=1 and araddr = req_addr.
  - wsel != 0: go to WR_REQ with awvalid=1, wvalid=1, wstrb = wsel, wdata = req_wdata.
- Read size: arsize = 3'd2.
- Write size (awsize from wsel):
  - One-hot wsel: 0.
  - 4'b0011 or 4'b1100: 1.
  - Any other pattern: 2.
- awaddr = req_addr unmodified.
- RD_ADDR: on arvalid & arready, drop arvalid, raise rready, go to RD_DATA.
- RD_DATA: on rvalid & rready:
  - Capture rdata into req_rdata and drop rready.
  - Go to DONE.
  - rresp, rid and rlast are ignored.
- WR_REQ: AW and W are independent.
  - Each valid drops in the cycle after its own handshake.
  - Handshakes may complete in either order or in the same cycle.
  - When both are complete, raise bready and go to WR_RESP.
- WR_RESP: on bvalid & bready, drop bready and go to DONE; bresp and bid are ignored.
- DONE:
  - refresh = 1 for exactly this cycle, then go to IDLE.
  - req_rdata holds its value until the next read completes; writes leave it unchanged.
- Request timing: the requester drops req_en on the edge after refresh, so req_en is 0 in the first IDLE cycle. IDLE samples req_en only in IDLE, so a stale req_en during DONE is never re-accepted.
- Latency:
  - Zero-wait-state read: 4 cycles from req_en to refresh (IDLE→RD_ADDR→RD_DATA→DONE).
  - Zero-wait-state write: also 4 cycles.
- Request inputs are don't-care outside IDLE; latched copies drive AXI.
- Once raised, arvalid/awvalid/wvalid stay high until handshake, with stable payload, per AXI.

Optional Feature:
- Macro: UNCACHE_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears in IDLE and increments in every non-IDLE, non-DONE state.
  - On reaching TIMEOUT_CYCLES, all valids and readies drop to 0, req_rdata is set to 32'hDEADBEEF, and the state goes to DONE, pulsing refresh.
  - An extra output port timeout (1 bit) pulses with that refresh.
  - This path breaks the AXI handshake rules and is for debug bring-up only.
- Undefined: no counter and no timeout port; the block waits indefinitely.

Test Plan:
- Read, addr 32'hBFD0_F010, arready=1, rvalid 3 cycles after rready with rdata 32'h1234_5678:
  - arsize=2 and arlen=0.
  - refresh pulses one cycle after the R handshake.
  - req_rdata = 32'h1234_5678 and stays so after refresh.
- Word write, wsel 4'b1111, wdata 32'hCAFE_F00D:
  - awready at cycle 1, wready at cycle 4, bvalid at cycle 6.
  - awvalid drops after cycle 1; wvalid drops after cycle 4.
  - bready rises after both handshakes; refresh one cycle after B.
- Byte write, wsel 4'b0100, wready before awready → awsize=0, wstrb=4'b0100, single refresh.
- Back-to-back, halfword write wsel 4'b0011 then read:
  - awsize=1.
  - The second request is accepted only from IDLE after refresh.
  - Exactly two refresh pulses total.
- resetn low while in RD_DATA → arvalid, rready and refresh go to 0 immediately with no clock; state is IDLE; no refresh after release.
- With UNCACHE_TIMEOUT_EN and TIMEOUT_CYCLES=16, arready held 0:
  - refresh and timeout pulse 17 cycles after acceptance (1 IDLE→RD_ADDR cycle + 16 counting cycles).
  - req_rdata = 32'hDEADBEEF.

Source files
------------

// File: rtl/uncache_axi_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uncache_axi_bridge                                         |
// | Description : Responder for the uncached-access request interface.       |
// |               Turns one held request (en/wsel/addr/wdata) into a single- |
// |               beat AXI4 read or write, returns read data and a one-cycle |
// |               refresh pulse on completion. One transaction in flight.    |
// | Ports       : clk, resetn (async, active low)                            |
// |               req_en/req_wsel/req_addr/req_wdata  request in             |
// |               req_rdata/refresh                   completion out         |
// |               AR/R/AW/W/B                         AXI4 manager channels  |
// |               timeout (only with UNCACHE_TIMEOUT_EN)                     |
// | Options     : `define UNCACHE_TIMEOUT_EN adds a watchdog that forces     |
// |               completion after TIMEOUT_CYCLES (debug bring-up only).     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module uncache_axi_bridge #(
  parameter logic [3:0]  AXI_ID         = 4'b0001,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  // request interface
  input  logic        req_en,
  input  logic [3:0]  req_wsel,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] req_rdata,
  output logic        refresh,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
`ifdef UNCACHE_TIMEOUT_EN
  ,
  output logic        timeout
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_aw_done;
  logic        r_w_done;
  logic [31:0] r_araddr;
  logic [31:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [2:0]  r_awsize;
  logic [31:0] r_rdata;

  logic        w_accept;
  logic        w_is_write;
  logic        w_awvalid;
  logic        w_wvalid;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_tmo_fire;

  // Narrowest AXI size covering the strobe pattern; only aligned halfwords
  // get size 1, anything irregular is issued as a full word with strobes.
  function automatic logic [2:0] f_awsize(input logic [3:0] i_sel);
    case (i_sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: f_awsize = 3'd0;
      4'b0011, 4'b1100:                   f_awsize = 3'd1;
      default:                            f_awsize = 3'd2;
    endcase
  endfunction

  assign w_accept   = (r_state == S_IDLE) && req_en;
  assign w_is_write = |req_wsel;

  // AW and W each drop independently once their own handshake is seen.
  assign w_awvalid  = (r_state == S_WR_REQ) && !r_aw_done;
  assign w_wvalid   = (r_state == S_WR_REQ) && !r_w_done;
  assign w_aw_hs    = w_awvalid && awready;
  assign w_w_hs     = w_wvalid && wready;

  // ---------------------------------------------------------------- watchdog
`ifdef UNCACHE_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;
  logic        r_timeout;

  assign w_tmo_fire = (r_state != S_IDLE) && (r_state != S_DONE) &&
                      (r_tmo_cnt == c_TMO_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tmo_cnt <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_tmo_cnt <= 16'd0;
      end else if (r_state != S_DONE) begin
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end
      // Set on the edge into DONE, cleared on the edge out of it.
      r_timeout <= w_tmo_fire;
    end
  end

  assign timeout = r_timeout;

  logic w_unused_ok;
  assign w_unused_ok = ^{rid, rresp, rlast, bid, bresp};
`else
  assign w_tmo_fire = 1'b0;

  logic w_unused_ok;
  assign w_unused_ok = ^{rid, rresp, rlast, bid, bresp, c_TMO_LAST};
`endif

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_en) begin
          w_state_nxt = w_is_write ? S_WR_REQ : S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        if (arready) begin
          w_state_nxt = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (rvalid) begin
          w_state_nxt = S_DONE;
        end
      end
      S_WR_REQ: begin
        // A channel counts as complete if it finished earlier or right now.
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
          w_state_nxt = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (bvalid) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_tmo_fire) begin
      w_state_nxt = S_DONE;
    end
  end

  // ---------------------------------------------- write channel completion
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if ((r_state != S_WR_REQ) || (w_state_nxt != S_WR_REQ)) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_w_done <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_araddr <= 32'd0;
      r_awaddr <= 32'd0;
      r_wdata  <= 32'd0;
      r_wstrb  <= 4'd0;
      r_awsize <= 3'd0;
      r_rdata  <= 32'd0;
    end else begin
      if (w_accept) begin
        if (w_is_write) begin
          r_awaddr <= req_addr;
          r_wdata  <= req_wdata;
          r_wstrb  <= req_wsel;
          r_awsize <= f_awsize(req_wsel);
        end else begin
          r_araddr <= req_addr;
        end
      end
      if (w_tmo_fire) begin
        r_rdata <= 32'hDEADBEEF;
      end else if ((r_state == S_RD_DATA) && rvalid) begin
        r_rdata <= rdata;
      end
    end
  end

  // --------------------------------------------------------------- outputs
  // Handshake controls decode straight from the state register so that an
  // asynchronous reset removes them immediately.
  assign arvalid   = (r_state == S_RD_ADDR);
  assign rready    = (r_state == S_RD_DATA);
  assign awvalid   = w_awvalid;
  assign wvalid    = w_wvalid;
  assign bready    = (r_state == S_WR_RESP);
  assign refresh   = (r_state == S_DONE);

  assign req_rdata = r_rdata;

  assign arid      = AXI_ID;
  assign araddr    = r_araddr;
  assign arlen     = 8'd0;
  assign arsize    = 3'd2;
  assign arburst   = 2'b01;

  assign awid      = AXI_ID;
  assign awaddr    = r_awaddr;
  assign awlen     = 8'd0;
  assign awsize    = r_awsize;
  assign awburst   = 2'b01;

  assign wdata     = r_wdata;
  assign wstrb     = r_wstrb;
  assign wlast     = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_uncache_axi_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uncache_axi_bridge                                      |
// | Description : Directed self-checking bench for uncache_axi_bridge.       |
// |               Inputs are driven and outputs sampled on the falling edge. |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_uncache_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_en;
  logic [3:0]  req_wsel;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_rdata;
  logic        refresh;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
`ifdef UNCACHE_TIMEOUT_EN
  logic        timeout;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_refresh = 0;
  int snap;

  always #5 clk = ~clk;

  uncache_axi_bridge #(
    .AXI_ID(4'b0001),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_en(req_en), .req_wsel(req_wsel), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rdata(req_rdata), .refresh(refresh),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef UNCACHE_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  // refresh is a function of state only, so sampling here is race-free.
  always @(negedge clk) begin
    if (refresh === 1'b1) n_refresh++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; req_en = 1'b0; req_wsel = 4'd0; req_addr = 32'd0; req_wdata = 32'd0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'd0; bresp = 2'd0; bvalid = 1'b0;

    // ---------------- reset state and fixed outputs
    repeat (2) tick();
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid",  wvalid,  0);
    check("rst_rready",  rready,  0);
    check("rst_bready",  bready,  0);
    check("rst_refresh", refresh, 0);
    check("rst_rdata",   req_rdata, 0);
    check("rst_araddr",  araddr, 0);
    check("rst_awaddr",  awaddr, 0);
    check("rst_wdata",   wdata,  0);
    check("rst_wstrb",   wstrb,  0);
    check("fix_arlen",   arlen,  0);
    check("fix_awlen",   awlen,  0);
    check("fix_arburst", arburst, 32'd1);
    check("fix_awburst", awburst, 32'd1);
    check("fix_wlast",   wlast,  1);
    check("fix_arid",    arid,   32'd1);
    check("fix_awid",    awid,   32'd1);
    resetn = 1'b1;
    tick();

    // ---------------- read, rvalid three cycles after rready
    arready = 1'b1; req_en = 1'b1; req_wsel = 4'b0000; req_addr = 32'hBFD0_F010;
    tick();
    check("rd_arvalid", arvalid, 1);
    check("rd_araddr",  araddr, 32'hBFD0_F010);
    check("rd_arsize",  arsize, 32'd2);
    check("rd_arlen",   arlen, 0);
    check("rd_rready0", rready, 0);
    tick();
    check("rd_arvalid_drop", arvalid, 0);
    check("rd_rready", rready, 1);
    tick();
    check("rd_wait_refresh", refresh, 0);
    tick();
    check("rd_wait_rready", rready, 1);
    tick();
    check("rd_wait2_refresh", refresh, 0);
    rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b10; rid = 4'h7; rlast = 1'b1;
    tick();
    check("rd_refresh", refresh, 1);
    check("rd_rready_drop", rready, 0);
    check("rd_rdata", req_rdata, 32'h1234_5678);
    rvalid = 1'b0; rlast = 1'b0; req_en = 1'b0; arready = 1'b0;
    tick();
    check("rd_refresh_end", refresh, 0);
    check("rd_rdata_hold", req_rdata, 32'h1234_5678);

    // ---------------- word write: aw@1, w@4, b@6
    req_en = 1'b1; req_wsel = 4'b1111; req_addr = 32'h1000_0040; req_wdata = 32'hCAFE_F00D;
    tick();
    check("ww_awvalid", awvalid, 1);
    check("ww_wvalid",  wvalid, 1);
    check("ww_awaddr",  awaddr, 32'h1000_0040);
    check("ww_awsize",  awsize, 32'd2);
    check("ww_wstrb",   wstrb, 32'hF);
    check("ww_wdata",   wdata, 32'hCAFE_F00D);
    awready = 1'b1;
    tick();
    check("ww_awvalid_drop", awvalid, 0);
    check("ww_wvalid_hold",  wvalid, 1);
    awready = 1'b0;
    tick();
    check("ww_bready_early", bready, 0);
    tick();
    check("ww_wvalid_c4", wvalid, 1);
    wready = 1'b1;
    tick();
    check("ww_wvalid_drop", wvalid, 0);
    check("ww_bready", bready, 1);
    wready = 1'b0;
    tick();
    check("ww_refresh_early", refresh, 0);
    bvalid = 1'b1; bresp = 2'b11; bid = 4'h9;
    tick();
    check("ww_refresh", refresh, 1);
    check("ww_bready_drop", bready, 0);
    check("ww_rdata_kept", req_rdata, 32'h1234_5678);
    bvalid = 1'b0; req_en = 1'b0;
    tick();
    check("ww_refresh_end", refresh, 0);

    // ---------------- byte write, W before AW
    snap = n_refresh;
    req_en = 1'b1; req_wsel = 4'b0100; req_addr = 32'h2000_0002; req_wdata = 32'h00AB_0000;
    tick();
    check("bw_awsize", awsize, 32'd0);
    check("bw_wstrb",  wstrb, 32'h4);
    check("bw_awaddr", awaddr, 32'h2000_0002);
    wready = 1'b1;
    tick();
    check("bw_wvalid_drop", wvalid, 0);
    check("bw_awvalid_hold", awvalid, 1);
    wready = 1'b0; awready = 1'b1;
    tick();
    check("bw_bready", bready, 1);
    awready = 1'b0; bvalid = 1'b1;
    tick();
    check("bw_refresh", refresh, 1);
    bvalid = 1'b0; req_en = 1'b0;
    tick();
    tick();
    check("bw_single_refresh", n_refresh - snap, 32'd1);

    // ---------------- back-to-back halfword write then read
    snap = n_refresh;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; arready = 1'b1; rvalid = 1'b1;
    rdata = 32'h55AA_33CC;
    req_en = 1'b1; req_wsel = 4'b0011; req_addr = 32'h3000_0000; req_wdata = 32'h0000_BEEF;
    tick();
    check("bb_awsize", awsize, 32'd1);
    check("bb_wstrb", wstrb, 32'h3);
    tick();
    check("bb_bready", bready, 1);
    tick();
    check("bb_refresh1", refresh, 1);
    // next request presented while still in DONE: must wait for IDLE
    req_wsel = 4'b0000; req_addr = 32'h3000_0100;
    tick();
    check("bb_not_from_done", arvalid, 0);
    tick();
    check("bb_rd_arvalid", arvalid, 1);
    check("bb_rd_araddr", araddr, 32'h3000_0100);
    tick();
    check("bb_rd_rready", rready, 1);
    tick();
    check("bb_refresh2", refresh, 1);
    check("bb_rdata", req_rdata, 32'h55AA_33CC);
    req_en = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
    tick();
    check("bb_two_refresh", n_refresh - snap, 32'd2);

    // ---------------- asynchronous reset in RD_DATA
    req_en = 1'b1; req_wsel = 4'b0000; req_addr = 32'h4000_0000;
    tick();
    tick();
    check("ar_rready_before", rready, 1);
    #2 resetn = 1'b0;
    #1;
    check("ar_arvalid", arvalid, 0);
    check("ar_rready", rready, 0);
    check("ar_refresh", refresh, 0);
    check("ar_rdata_clr", req_rdata, 0);
    tick();
    req_en = 1'b0; arready = 1'b0;
    resetn = 1'b1;
    snap = n_refresh;
    repeat (4) tick();
    check("ar_no_refresh", n_refresh - snap, 0);
    check("ar_idle", arvalid, 0);

`ifdef UNCACHE_TIMEOUT_EN
    // ---------------- watchdog with arready stuck low
    begin
      int early;
      early = 0;
      req_en = 1'b1; req_wsel = 4'b0000; req_addr = 32'h5000_0000;
      for (int k = 1; k <= 16; k++) begin
        tick();
        if (refresh !== 1'b0) early++;
      end
      check("to_no_early", early, 0);
      tick();
      check("to_refresh", refresh, 1);
      check("to_timeout", timeout, 1);
      check("to_rdata", req_rdata, 32'hDEADBEEF);
      check("to_arvalid", arvalid, 0);
      req_en = 1'b0;
      tick();
      check("to_refresh_end", refresh, 0);
      check("to_timeout_end", timeout, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
